psc_frame_scheduler: RTL
========================

PSC_FRAME_SCHEDULER -- requirements
Module: psc_frame_scheduler

Interface
REQ-001 Parameter FRAME_LEN, default 10, bytes per frame (2..16).
REQ-002 Parameter HEARTBEAT_TICKS, default 1000, idle symbol slots before a heartbeat frame is due (>=2).
REQ-003 clk  input  1  50 MHz system clock; the block has one clock and all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sym_tick  input  1  one-clk strobe marking a byte slot (1 MHz).
REQ-006 trig_req  input  1  one-clk EVR trigger pulse, already edge-detected.
REQ-007 sp_req  input  1  setpoint frame request level; held high until sp_ack.
REQ-008 byte_load  output  1  one-clk strobe: load the byte at byte_addr into the encoder/shift path.
REQ-009 byte_addr  output  4  data ROM byte index within the current frame.
REQ-010 frame_sel  output  2  frame type: 00 none, 01 trigger, 10 setpoint, 11 heartbeat.
REQ-011 frame_active  output  1  high from the first byte_load of a frame through the end of its gap slot.
REQ-012 sp_ack  output  1  one-clk pulse: setpoint frame fully issued.
REQ-013 trig_overrun  output  1  one-clk pulse: trigger lost because one was already pending.

Function
REQ-014 States SHALL be IDLE, SEND and GAP; all state changes occur only in a cycle with sym_tick=1.
REQ-015 trig_pending SHALL set on trig_req and clear when a trigger frame is granted; a trig_req in the grant cycle counts as pending.
REQ-016 trig_req while trig_pending=1 and not being granted SHALL pulse trig_overrun the next cycle; pending stays set.
REQ-017 In IDLE on sym_tick, grant priority SHALL be trig_pending > sp_req > heartbeat_due; with no request, stay IDLE.
REQ-018 On grant, SHALL enter SEND and assert byte_load the next clk with byte_addr=0 and frame_sel=granted type.
REQ-019 In SEND, each sym_tick SHALL issue the next byte: byte_load one clk later, byte_addr incremented by 1.
REQ-020 After the byte with byte_addr=FRAME_LEN-1, the next sym_tick SHALL enter GAP (no byte_load); the following sym_tick SHALL enter IDLE and grant in that same cycle if any request is pending.
REQ-021 byte_addr and frame_sel SHALL hold their values between byte_loads and return to 0 on entry to IDLE.
REQ-022 sp_ack SHALL pulse coincident with the byte_load of setpoint byte FRAME_LEN-1.
REQ-023 Heartbeat counter SHALL increment on each sym_tick in IDLE, clear on any grant, and saturate at HEARTBEAT_TICKS; heartbeat_due = (count == HEARTBEAT_TICKS).
REQ-024 byte_load SHALL never assert in two consecutive clks and never outside SEND.

Reset
REQ-025 While reset=1: state IDLE, all outputs 0, trig_pending 0, heartbeat counter 0.
REQ-026 Reset mid-frame SHALL abort the frame with no sp_ack; requests present after reset release are re-evaluated normally.

Configuration
REQ-027 Macro PSC_TRIG_PREEMPT_EN: when defined, trig_pending during a setpoint or heartbeat frame in SEND SHALL abort it at the next sym_tick and start the trigger frame there, with byte_load at addr 0 and no GAP; the aborted frame gets no sp_ack, and sp_req is served again later.
REQ-028 When PSC_TRIG_PREEMPT_EN is undefined, a trigger always waits for the current frame and its GAP slot to end.

Verification
REQ-029 trig_req at clk 5 in IDLE, sym_tick every 50 clks from clk 50 -> byte_load at clk 51 with addr 0 and frame_sel 01; addr 9 at clk 501; GAP at clk 550; IDLE at 600.
REQ-030 sp_req and trig_req both pending at one sym_tick -> trigger frame first; setpoint frame granted at the sym_tick ending the GAP; sp_ack with addr 9.
REQ-031 No requests, HEARTBEAT_TICKS=4 -> heartbeat frame (frame_sel 11) granted on the 5th IDLE sym_tick.
REQ-032 Two trig_req 3 clks apart during SEND -> one trig_overrun pulse; exactly one extra trigger frame follows.
REQ-033 With PSC_TRIG_PREEMPT_EN, trig_req during setpoint byte 4 -> next byte_load has addr 0 and frame_sel 01; no sp_ack; setpoint frame resent afterward. Without the macro, setpoint completes and the trigger follows the GAP.
REQ-034 reset asserted at setpoint byte 6 -> all outputs 0 the next clk; no sp_ack; held sp_req is granted at the first sym_tick after release.

Source files
------------

// File: rtl/psc_frame_scheduler.sv
// Frame scheduler: arbitrates trigger, setpoint and heartbeat frames onto byte slots.
// Optional build macro PSC_TRIG_PREEMPT_EN lets a pending trigger abort a setpoint/heartbeat frame.
module psc_frame_scheduler #(
    parameter int unsigned FRAME_LEN       = 10,
    parameter int unsigned HEARTBEAT_TICKS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sym_tick,
    input  logic       trig_req,
    input  logic       sp_req,
    output logic       byte_load,
    output logic [3:0] byte_addr,
    output logic [1:0] frame_sel,
    output logic       frame_active,
    output logic       sp_ack,
    output logic       trig_overrun
);

    localparam int unsigned HbW = $clog2(HEARTBEAT_TICKS + 1);
    localparam logic [HbW-1:0] HbMax = HbW'(HEARTBEAT_TICKS);
    localparam logic [3:0] LastAddr = 4'(FRAME_LEN - 1);

    localparam logic [1:0] SelNone = 2'b00;
    localparam logic [1:0] SelTrig = 2'b01;
    localparam logic [1:0] SelSp   = 2'b10;
    localparam logic [1:0] SelHb   = 2'b11;

`ifdef PSC_TRIG_PREEMPT_EN
    localparam bit PreemptEn = 1'b1;
`else
    localparam bit PreemptEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e         state_q, state_d;
    logic [3:0]     addr_q, addr_d;
    logic [1:0]     sel_q, sel_d;
    logic           load_q, load_d;
    logic           ack_q, ack_d;
    logic           ovr_q, ovr_d;
    logic           pend_q, pend_d;
    logic [HbW-1:0] hb_q, hb_d;

    logic       hb_due;
    logic       start;
    logic       grant_trig;
    logic [1:0] grant_sel;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        load_d     = 1'b0;
        hb_d       = hb_q;
        start      = 1'b0;
        hb_due     = (hb_q == HbMax);
        grant_sel  = SelNone;

        if (pend_q) begin
            grant_sel = SelTrig;
        end else if (sp_req) begin
            grant_sel = SelSp;
        end else if (hb_due) begin
            grant_sel = SelHb;
        end

        case (state_q)
            StIdle: begin
                if (sym_tick) begin
                    if (grant_sel != SelNone) begin
                        start = 1'b1;
                    end else if (!hb_due) begin
                        hb_d = hb_q + HbW'(1);
                    end
                end
            end
            StSend: begin
                if (sym_tick) begin
                    if (PreemptEn && pend_q && (sel_q != SelTrig)) begin
                        start = 1'b1;
                    end else if (addr_q == LastAddr) begin
                        state_d = StGap;
                    end else begin
                        addr_d = addr_q + 4'd1;
                        load_d = 1'b1;
                    end
                end
            end
            StGap: begin
                // The slot ending GAP doubles as an idle arbitration slot.
                if (sym_tick) begin
                    if (grant_sel != SelNone) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                        addr_d  = 4'd0;
                        sel_d   = SelNone;
                        if (!hb_due) begin
                            hb_d = hb_q + HbW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                addr_d  = 4'd0;
                sel_d   = SelNone;
            end
        endcase

        if (start) begin
            state_d = StSend;
            addr_d  = 4'd0;
            sel_d   = grant_sel;
            load_d  = 1'b1;
            hb_d    = '0;
        end

        grant_trig = start && (grant_sel == SelTrig);
        ack_d      = load_d && (sel_d == SelSp) && (addr_d == LastAddr);
        pend_d     = (pend_q && !grant_trig) || trig_req;
        ovr_d      = trig_req && pend_q && !grant_trig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= 4'd0;
            sel_q   <= SelNone;
            load_q  <= 1'b0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
            hb_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            load_q  <= load_d;
            ack_q   <= ack_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
            hb_q    <= hb_d;
        end
    end

    assign byte_load    = load_q;
    assign byte_addr    = addr_q;
    assign frame_sel    = sel_q;
    assign frame_active = (state_q != StIdle);
    assign sp_ack       = ack_q;
    assign trig_overrun = ovr_q;

endmodule
